// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler and its divider.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    WRITE  = 2'd2
  } sched_state_t;

  localparam int DIV_W      = 32;
  localparam int DIV_CYCLES = 32;

  // A nonzero rate faster than the clock still has to tick, so it runs at
  // the fastest possible period instead of disabling the channel.
  function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] q);
    return (q == '0) ? DIV_W'(1) : q;
  endfunction

endpackage

// File: rtl/tick_scheduler_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The start cycle already
// performs the first iteration, so done pulses on the cycle after the 32nd
// iteration and the quotient is stable from then until the next start.
module seq_divider
  import tick_sched_pkg::*;
(
  input  logic             inClock,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  logic [DIV_W-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             act_q;

  logic [DIV_W-1:0] rem_in, quo_in, dvs_in, rem_nx, quo_nx;
  logic [DIV_W:0]   trial, diff;

  // One restoring step; on start the operands come straight from the ports.
  always_comb begin
    rem_in = start ? '0       : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor  : dvs_q;
    trial  = {rem_in, quo_in[DIV_W-1]};
    diff   = trial - {1'b0, dvs_in};
    if (!diff[DIV_W]) begin
      rem_nx = diff[DIV_W-1:0];
      quo_nx = {quo_in[DIV_W-2:0], 1'b1};
    end else begin
      rem_nx = trial[DIV_W-1:0];
      quo_nx = {quo_in[DIV_W-2:0], 1'b0};
    end
  end

  // Iteration state and the done pulse.
  always_ff @(posedge inClock) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        dvs_q <= divisor;
        cnt_q <= CW'(DIV_CYCLES - 1);
        act_q <= 1'b1;
      end else if (act_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          act_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/tick_scheduler.sv
// Per-channel tick enables derived from requested rates. One shared divider,
// granted round-robin, turns each rate into a period; periods change only at
// a channel's tick boundary so no runt or doubled tick is produced.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter logic [DIV_W-1:0] BASE_SPEED = 32'd50_000_000,
  parameter int               N_CH       = 4
) (
  input  logic                       inClock,
  input  logic                       reset,
  input  logic [N_CH-1:0][DIV_W-1:0] speedReq,
  input  logic [N_CH-1:0]            speedLoad,
  input  logic                       pause,
  output logic [N_CH-1:0]            tick,
  output logic [N_CH-1:0]            loadPending,
  output logic                       busy
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0][DIV_W-1:0] rate_q;
  logic [N_CH-1:0]            pending_q;
  sched_state_t               state_q;
  logic [GW-1:0]              grant_q, rr_q;
  logic [DIV_W-1:0]           quo_q;
  logic                       busy_q;

  logic          gnt_found, grant_now, div_start, div_done;
  logic [GW-1:0] gnt_c, rr_nx;
  logic [DIV_W-1:0] div_quo;

  // First pending channel at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_c     = '0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % N_CH;
      if (!gnt_found && pending_q[idx]) begin
        gnt_found = 1'b1;
        gnt_c     = GW'(idx);
      end
    end
  end

  assign grant_now = (state_q == IDLE) && gnt_found;
  assign div_start = grant_now && (rate_q[gnt_c] != '0);
  assign rr_nx     = (gnt_c == GW'(N_CH - 1)) ? '0 : gnt_c + 1'b1;

  // Rate capture; a load in the grant cycle re-arms pending so it is redone.
  always_ff @(posedge inClock) begin
    if (!reset) begin
      rate_q    <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (speedLoad[i]) begin
          pending_q[i] <= 1'b1;
          rate_q[i]    <= speedReq[i];
        end else if (grant_now && (gnt_c == GW'(i))) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  seq_divider u_div (
    .inClock  (inClock),
    .reset    (reset),
    .start    (div_start),
    .dividend (BASE_SPEED),
    .divisor  (rate_q[gnt_c]),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Arbiter FSM: grant, divide (or skip for rate 0), write one period.
  always_ff @(posedge inClock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            grant_q <= gnt_c;
            rr_q    <= rr_nx;
            busy_q  <= 1'b1;
            if (rate_q[gnt_c] == '0) begin
              quo_q   <= '0;
              state_q <= WRITE;
            end else begin
              state_q <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (div_done) begin
            quo_q   <= clamp_period(div_quo);
            state_q <= WRITE;
          end
        end
        WRITE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_W-1:0] period_q, period_nx_q, cnt_q;
    logic             nv_q, tick_q, wr_en;

    assign wr_en = (state_q == WRITE) && (grant_q == GW'(g));

    // Channel counter; the write is ordered last so a fresh period written
    // on a boundary edge is kept for the following boundary.
    always_ff @(posedge inClock) begin
      if (!reset) begin
        period_q    <= '0;
        period_nx_q <= '0;
        cnt_q       <= '0;
        nv_q        <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if ((period_q != '0) && !pause) begin
          if (cnt_q == period_q - DIV_W'(1)) begin
            tick_q <= 1'b1;
            cnt_q  <= '0;
            if (nv_q) begin
              period_q <= period_nx_q;
              nv_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        if (wr_en) begin
          if (period_q == '0) begin
            period_q <= quo_q;
            cnt_q    <= '0;
          end else begin
            period_nx_q <= quo_q;
            nv_q        <= 1'b1;
          end
        end
      end
    end

    assign tick[g]        = tick_q;
    assign loadPending[g] = pending_q[g] | (busy_q && (grant_q == GW'(g))) | nv_q;
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler at BASE_SPEED=100, N_CH=4.
module tb_tick_scheduler;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][31:0] speedReq;
  logic [3:0]       speedLoad;
  logic             pause;
  logic [3:0]       tick, loadPending;
  logic             busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  int expq[4][$];

  tick_scheduler #(.BASE_SPEED(32'd100), .N_CH(4)) dut (
    .inClock     (clk),
    .reset       (rst),
    .speedReq    (speedReq),
    .speedLoad   (speedLoad),
    .pause       (pause),
    .tick        (tick),
    .loadPending (loadPending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Tick monitor: every observed tick must match the head of its channel queue.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        if (tick[c]) begin
          if (expq[c].size() == 0) chk($sformatf("tick%0d_extra", c), cyc, -1);
          else chk($sformatf("tick%0d", c), cyc, expq[c].pop_front());
        end
      end
    end
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load(input int ch, input logic [31:0] r, output int t);
    speedReq[ch]  = r;
    speedLoad[ch] = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    speedLoad = '0;
  endtask

  task automatic push_stream(input int ch, input int first, input int p, input int e);
    for (int x = first; x <= e; x += p) expq[ch].push_back(x);
  endtask

  // Ticks every p active (unpaused) edges after the pickup edge.
  task automatic push_paused(input int ch, input int pick, input int p,
                             input int ps, input int pe, input int e);
    int k;
    k = 0;
    for (int x = pick + 1; x <= e; x++) begin
      if (x < ps || x > pe) begin
        k++;
        if (k % p == 0) expq[ch].push_back(x);
      end
    end
  endtask

  task automatic end_window(input string tag);
    mon_en = 1'b0;
    for (int c = 0; c < 4; c++) chk($sformatf("%s_left%0d", tag, c), expq[c].size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b0;
    for (int c = 0; c < 4; c++) expq[c].delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_lp", loadPending, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t, t2, t3, e, p, tk, wr;
    bit sw;
    rst = 1'b0; pause = 1'b0; speedLoad = '0; speedReq = '0;

    // Idle after reset.
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_lp", loadPending, 0);
    end
    end_window("idle");

    // ch0 rate 10, then rate 25 while running.
    do_reset();
    mon_en = 1'b1;
    load(0, 32'd10, t);
    chk("s2_busy_t", busy, 0);
    wr = t + 60 + 34;
    e  = t + 160;
    tk = t + 44; p = 10; sw = 1'b0;
    while (tk <= e) begin
      expq[0].push_back(tk);
      if (!sw && tk > wr) begin p = 4; sw = 1'b1; end
      tk += p;
    end
    at(t + 1);  chk("s2_busy_g", busy, 1); chk("s2_lp_g", loadPending, 4'b0001);
    at(t + 33); chk("s2_busy_d", busy, 1);
    at(t + 35); chk("s2_busy_w", busy, 0); chk("s2_lp_w", loadPending, 0);
    at(t + 59); load(0, 32'd25, t2);
    at(t2 + 1); chk("s3_busy_g", busy, 1);
    at(t2 + 40); chk("s3_lp_nv", loadPending, 4'b0001);
    at(e);
    end_window("rate");

    // All four channels loaded in one cycle.
    do_reset();
    mon_en = 1'b1;
    speedReq = {32'd200, 32'd50, 32'd20, 32'd10};
    speedLoad = 4'hf;
    t = cyc + 1;
    @(negedge clk);
    speedLoad = '0;
    e = t + 200;
    push_stream(0, t + 44, 10, e);
    push_stream(1, t + 73, 5, e);
    push_stream(2, t + 104, 2, e);
    push_stream(3, t + 137, 1, e);
    at(t + 2);   chk("s4_lp_a", loadPending, 4'hf);
    at(t + 35);  chk("s4_busy_g1", busy, 1);
    at(t + 40);  chk("s4_lp_b", loadPending, 4'he);
    at(t + 70);  chk("s4_lp_c", loadPending, 4'hc);
    at(t + 104); chk("s4_lp_d", loadPending, 4'h8);
    at(t + 140); chk("s4_lp_e", loadPending, 4'h0);
    at(e);
    end_window("all4");

    // Pause while ch1 runs at period 5; ch2 loaded during the pause.
    do_reset();
    mon_en = 1'b1;
    load(1, 32'd20, t);
    e = t + 150;
    push_paused(1, t + 34, 5, t + 50, t + 86, e);
    push_paused(2, t + 84, 2, t + 50, t + 86, e);
    at(t + 49);
    pause = 1'b1;
    load(2, 32'd50, t3);
    chk("s5_load_edge", t3, t + 50);
    at(t3 + 1);  chk("s5_busy_p", busy, 1);
    at(t3 + 35); chk("s5_lp_p", loadPending, 0);
    at(t3 + 36); pause = 1'b0;
    at(e);
    end_window("pause");

    // ch2 rate 10 then rate 0 during its divide.
    do_reset();
    mon_en = 1'b1;
    load(2, 32'd10, t);
    expq[2].push_back(t + 44);
    at(t + 9);  load(2, 32'd0, t2);
    at(t + 35); chk("s6_busy_rg", busy, 1); chk("s6_lp_rg", loadPending, 4'b0100);
    at(t + 37); chk("s6_busy_w", busy, 0); chk("s6_lp_nv", loadPending, 4'b0100);
    at(t + 46); chk("s6_lp_done", loadPending, 0);
    e = t + 120;
    at(e);
    end_window("zero");

    // Reset in the middle of a divide: nothing may be written.
    do_reset();
    mon_en = 1'b1;
    load(2, 32'd10, t);
    at(t + 15); chk("s7_busy_pre", busy, 1);
    rst = 1'b0;
    at(t + 16); chk("s7_busy_r", busy, 0); chk("s7_lp_r", loadPending, 0); chk("s7_tick_r", tick, 0);
    rst = 1'b1;
    at(t + 40); chk("s7_busy_post", busy, 0); chk("s7_lp_post", loadPending, 0);
    at(t + 120);
    end_window("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
